// File: rtl/id_ex_operand_stage.sv
// ID/EX operand capture: register-file read ports bypassed from EX, MEM and WB,
// decode stall on unready producers, and a valid/ready latch toward execute.

module id_ex_fwd_lane #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ok,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ok,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] opnd,
  output logic              not_ready
);
  logic rs_nz, ex_hit, mem_hit, wb_hit;

  // x0 never matches a producer, even one that claims to write rd==0
  assign rs_nz   = |rs;
  assign ex_hit  = rs_nz & ex_wr  & (ex_rd  == rs);
  assign mem_hit = rs_nz & mem_wr & (mem_rd == rs);
  assign wb_hit  = rs_nz & wb_wr  & (wb_rd  == rs);

  // the first match decides readiness; an older ready copy never hides it
  always_comb begin
    opnd      = rf_data;
    not_ready = 1'b0;
    if (!rs_nz) begin
      opnd = '0;
    end else if (ex_hit) begin
      opnd      = ex_result;
      not_ready = use_src & ~ex_ok;
    end else if (mem_hit) begin
      opnd      = mem_data;
      not_ready = use_src & ~mem_ok;
    end else if (wb_hit) begin
      opnd = wb_data;
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_result_ok,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_ok,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [31:0]       stall_cnt
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [NUM_LANES-1:0][DATA_W-1:0] opnd;
    logic [REG_AW-1:0]                rd;
    logic                             regwrite;
    logic                             memread;
  } lat_t;

  lat_t                             lat_q, lat_d;
  logic [NUM_LANES-1:0]             lane_use;
  logic [NUM_LANES-1:0][REG_AW-1:0] lane_rs;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_rf;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_opnd;
  logic [NUM_LANES-1:0]             lane_nr;
  logic                             ex_wr, hazard, accept;

  assign lane_use = {id_use_rs2, id_use_rs1};
  assign lane_rs  = {id_rs2, id_rs1};
  assign lane_rf  = {rf_rs2_data, rf_rs1_data};
  assign ex_wr    = ex_valid & lat_q.regwrite;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    id_ex_fwd_lane #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_lane (
      .use_src   (lane_use[g]),
      .rs        (lane_rs[g]),
      .rf_data   (lane_rf[g]),
      .ex_wr     (ex_wr),
      .ex_rd     (lat_q.rd),
      .ex_result (ex_result),
      .ex_ok     (ex_result_ok),
      .mem_wr    (mem_regwrite),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ok    (mem_data_ok),
      .wb_wr     (wb_regwrite),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .opnd      (lane_opnd[g]),
      .not_ready (lane_nr[g])
    );
  end

  assign hazard   = id_valid & (|lane_nr);
  assign id_ready = ~hazard & (~ex_valid | ex_ready) & ~flush;
  assign accept   = id_valid & id_ready;

  always_comb begin
    lat_d.opnd     = lane_opnd;
    lat_d.rd       = id_rd;
    lat_d.regwrite = id_regwrite;
    lat_d.memread  = id_memread;
  end

  // accept already excludes flush and a held latch, so it needs no extra guard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      lat_q     <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= 1'b1;
        lat_q    <= lat_d;
      end else if (~ex_valid | ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (hazard & ~flush & ~(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign ex_rs1_data = lat_q.opnd[0];
  assign ex_rs2_data = lat_q.opnd[1];
  assign ex_rd       = lat_q.rd;
  assign ex_regwrite = lat_q.regwrite;
  assign ex_memread  = lat_q.memread;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized and directed stimulus for id_ex_operand_stage, checked by a
// scoreboard fed from a priority-list forwarding model.

module tb_id_ex_operand_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        id_valid, id_ready, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [31:0] rf_rs1_data, rf_rs2_data, ex_result, mem_data, wb_data;
  logic        ex_result_ok, mem_regwrite, mem_data_ok, wb_regwrite, ex_ready, flush;
  logic        ex_valid, ex_regwrite, ex_memread;
  logic [31:0] ex_rs1_data, ex_rs2_data, stall_cnt;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_result(ex_result), .ex_result_ok(ex_result_ok),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_data(mem_data), .mem_data_ok(mem_data_ok),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit          id_valid, use1, use2, regwrite, memread, ex_ok, mem_rw, mem_ok, wb_rw, ex_ready, flush;
    logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd;
    logic [31:0] rf1, rf2, ex_res, mem_d, wb_d;
  } stim_t;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          rw, mr;
  } exp_t;

  stim_t       s;
  exp_t        q[$];
  int          tests = 0, fails = 0;
  bit          m_valid = 0, m_rw = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] c0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '{default: 0};
    t.ex_ready = 1'b1;
    return t;
  endfunction

  // producers listed youngest first; the first one naming rs wins outright
  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf,
                                          output bit unready);
    bit          hit[3];
    bit          ok[3];
    logic [31:0] d[3];
    hit = '{m_valid && m_rw && m_rd == rs, s.mem_rw && s.mem_rd == rs, s.wb_rw && s.wb_rd == rs};
    ok  = '{s.ex_ok, s.mem_ok, 1'b1};
    d   = '{s.ex_res, s.mem_d, s.wb_d};
    unready = 1'b0;
    if (rs == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (hit[i]) begin
        unready = !ok[i];
        return d[i];
      end
    return rf;
  endfunction

  task automatic drive();
    id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; id_rd = s.rd;
    id_regwrite = s.regwrite; id_memread = s.memread;
    rf_rs1_data = s.rf1; rf_rs2_data = s.rf2;
    ex_result = s.ex_res; ex_result_ok = s.ex_ok;
    mem_regwrite = s.mem_rw; mem_rd = s.mem_rd; mem_data = s.mem_d; mem_data_ok = s.mem_ok;
    wb_regwrite = s.wb_rw; wb_rd = s.wb_rd; wb_data = s.wb_d;
    ex_ready = s.ex_ready; flush = s.flush;
  endtask

  task automatic apply();
    bit u1, u2, hz, rdy;
    logic [31:0] ea, eb;
    @(negedge clk);
    drive();
    #1;
    ea  = resolve(s.rs1, s.rf1, u1);
    eb  = resolve(s.rs2, s.rf2, u2);
    hz  = s.id_valid && ((s.use1 && u1) || (s.use2 && u2));
    rdy = !hz && (!m_valid || s.ex_ready) && !s.flush;
    check("id_ready", id_ready, rdy);
    check("ex_valid", ex_valid, m_valid);
    check("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    if (hz && !s.flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (s.flush) begin
      m_valid = 0;
      q.delete();
    end else if (s.id_valid && rdy) begin
      m_valid = 1; m_rd = s.rd; m_rw = s.regwrite;
      q.push_back('{ea, eb, s.rd, s.regwrite, s.memread});
    end else if (!m_valid || s.ex_ready) begin
      m_valid = 0;
    end
  endtask

  // monitor: every completed EX handshake retires the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && ex_valid && ex_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got rd %0d with no expected entry", ex_rd);
        end else begin
          e = q.pop_front();
          check("ex_rs1_data", ex_rs1_data, e.a);
          check("ex_rs2_data", ex_rs2_data, e.b);
          check("ex_rd", ex_rd, e.rd);
          check("ex_regwrite", ex_regwrite, e.rw);
          check("ex_memread", ex_memread, e.mr);
        end
      end
    end
  end

  initial begin
    s = idle();
    drive();
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_rs1", ex_rs1_data, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk) rst = 1'b1;

    // independent ops: rs1=3 from register file
    s = idle(); s.id_valid = 1; s.rs1 = 3; s.use1 = 1; s.rf1 = 32'h11; s.rd = 4; s.regwrite = 1;
    apply(); apply();
    #1 check("indep_rs1", ex_rs1_data, 32'h11);

    // EX forwarding, then the rd==0 producer case
    s = idle(); s.id_valid = 1; s.rd = 5; s.regwrite = 1; apply();
    s = idle(); s.id_valid = 1; s.rs2 = 5; s.use2 = 1; s.rf2 = 32'h77; s.ex_res = 32'hA5; s.ex_ok = 1;
    apply();
    #1 check("ex_fwd_rs2", ex_rs2_data, 32'hA5);
    s = idle(); s.id_valid = 1; s.rd = 0; s.regwrite = 1; apply();
    s = idle(); s.id_valid = 1; s.rs2 = 0; s.use2 = 1; s.rf2 = 32'h99; s.ex_res = 32'hBB; s.ex_ok = 1;
    apply();
    #1 check("x0_rs2", ex_rs2_data, 32'h0);

    // priority: EX/MEM/WB all target x7
    s = idle(); s.id_valid = 1; s.rd = 7; s.regwrite = 1; apply();
    s = idle(); s.id_valid = 1; s.rs1 = 7; s.use1 = 1; s.ex_res = 1; s.ex_ok = 1;
    s.mem_rw = 1; s.mem_rd = 7; s.mem_d = 2; s.mem_ok = 1; s.wb_rw = 1; s.wb_rd = 7; s.wb_d = 3;
    s.rd = 7; s.regwrite = 1;
    apply();
    #1 check("prio_ex", ex_rs1_data, 32'h1);
    s.ex_ok = 0; apply();
    s = idle(); apply();

    // load-use: one EX stall, one MEM stall, then WB forward
    s = idle(); s.id_valid = 1; s.rd = 9; s.regwrite = 1; s.memread = 1; apply();
    c0 = m_cnt;
    s = idle(); s.id_valid = 1; s.rs1 = 9; s.use1 = 1; s.rd = 10; s.regwrite = 1; apply();
    s.mem_rw = 1; s.mem_rd = 9; apply();
    s.mem_rw = 0; s.wb_rw = 1; s.wb_rd = 9; s.wb_d = 32'hDEAD; apply();
    #1 check("loaduse_data", ex_rs1_data, 32'hDEAD);
    check("loaduse_stalls", stall_cnt, c0 + 32'd2);

    // back-pressure with flush on the second held cycle
    s = idle(); s.id_valid = 1; s.rd = 3; s.regwrite = 1; apply();
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.use1 = 1; s.rf1 = 5; s.ex_ready = 0; apply();
    s.flush = 1; apply();
    #1 check("flush_drop", ex_valid, 0);
    s.flush = 0; apply();
    s = idle(); apply();

    // async reset while a stalled instruction is held
    s = idle(); s.id_valid = 1; s.rd = 9; s.regwrite = 1; s.memread = 1; apply();
    s = idle(); s.id_valid = 1; s.rs1 = 9; s.use1 = 1; s.ex_ready = 0; apply(); apply();
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check("arst_ex_valid", ex_valid, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    m_valid = 0; m_cnt = '0; q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    s = idle(); s.id_valid = 1; s.rs1 = 2; s.use1 = 1; s.rf1 = 32'h1234; s.rd = 2; apply();
    #1 check("post_rst_rs1", ex_rs1_data, 32'h1234);

    for (int n = 0; n < 3000; n++) begin
      s.id_valid = $urandom_range(0, 3) != 0;
      s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
      s.use1 = $urandom_range(0, 3) != 0; s.use2 = $urandom_range(0, 3) != 0;
      s.rd = 5'($urandom_range(0, 7)); s.regwrite = $urandom_range(0, 3) != 0;
      s.memread = $urandom_range(0, 1) != 0;
      s.rf1 = $urandom; s.rf2 = $urandom; s.ex_res = $urandom; s.mem_d = $urandom; s.wb_d = $urandom;
      s.ex_ok = $urandom_range(0, 3) != 0; s.mem_ok = $urandom_range(0, 3) != 0;
      s.mem_rw = $urandom_range(0, 1) != 0; s.mem_rd = 5'($urandom_range(0, 7));
      s.wb_rw = $urandom_range(0, 1) != 0; s.wb_rd = 5'($urandom_range(0, 7));
      s.ex_ready = $urandom_range(0, 3) != 0; s.flush = $urandom_range(0, 15) == 0;
      apply();
    end
    s = idle(); apply(); apply();
    check("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-capture stage between decode and execute. It takes the two combinational read ports of the integer register file and resolves read-after-write hazards by forwarding from EX, MEM and WB, in that priority order. When a needed result is not ready yet, it stalls decode. It registers the resolved operands into the ID/EX pipeline latch under a valid/ready handshake with the execute stage.

## Interface
- `DATA_W`, 32, operand width
- `REG_AW`, 5, register index width (32 registers; x0 hardwired zero)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `id_valid` in 1: decode presents an instruction
- `id_ready` out 1: stage accepts the decode instruction this cycle
- `id_rs1`, `id_rs2` in REG_AW: source indices; also drive register-file `read_r1`/`read_r2`
- `id_use_rs1`, `id_use_rs2` in 1: source is actually consumed
- `id_rd` in REG_AW: destination index
- `id_regwrite` in 1: instruction writes `id_rd`
- `id_memread` in 1: instruction is a load
- `rf_rs1_data`, `rf_rs2_data` in DATA_W: register-file read data (pre-write value in the WB cycle)
- `ex_result` in DATA_W: ALU result of the instruction currently held in this stage's output
- `ex_result_ok` in 1: `ex_result` is final (0 for loads and multi-cycle ops)
- `mem_regwrite` in 1, `mem_rd` in REG_AW, `mem_data` in DATA_W, `mem_data_ok` in 1: MEM-stage producer
- `wb_regwrite` in 1, `wb_rd` in REG_AW, `wb_data` in DATA_W: WB producer, same signals that drive the register file
- `ex_ready` in 1: execute accepts the latch contents
- `flush` in 1: branch/trap kill of the decode instruction and latch contents
- `ex_valid` out 1; `ex_rs1_data`, `ex_rs2_data` out DATA_W; `ex_rd` out REG_AW; `ex_regwrite`, `ex_memread` out 1
- `stall_cnt` out 32: saturating count of hazard-stall cycles

## Operation
- Per source `s` with `id_use_s=1` and `id_rs_s≠0`, the forwarded value is the first match in this order:
  - EX: `ex_valid & ex_regwrite & ex_rd==rs` gives `ex_result`. This match is ready only when `ex_result_ok`.
  - MEM: `mem_regwrite & mem_rd==rs` gives `mem_data`. This match is ready only when `mem_data_ok`.
  - WB: `wb_regwrite & wb_rd==rs` gives `wb_data`. Always ready.
  - Otherwise `rf_rs*_data`.
- A source with `id_rs_s==0` yields 0 and never matches any producer, even if a producer has `rd==0`.
- An unused source (`id_use_s=0`) never causes a stall. Its captured value is don't-care, but it must still be deterministic per the priority above.
- `hazard = id_valid & (a used source's highest-priority match is not ready)`. A lower-priority ready match never overrides a higher-priority unready one.
- `id_ready = ~hazard & (~ex_valid | ex_ready) & ~flush`.
- Latch update priority, on each rising edge:
  1. `flush`: clear `ex_valid`. Other latch fields are don't-care.
  2. `ex_valid & ~ex_ready`: hold every output unchanged.
  3. `id_valid & id_ready`: load `ex_valid=1`, the forwarded operands, `ex_rd`, `ex_regwrite`, `ex_memread`.
  4. Otherwise, insert a bubble with `ex_valid=0`. This covers both the hazard case and `~id_valid`.
- `stall_cnt` increments by 1 on each cycle with `hazard & ~flush`, and saturates at 0xFFFF_FFFF.

## Timing
- Reset (async assert, `rst=0`): `ex_valid=0`, all data/index/control outputs 0, `stall_cnt=0`. Reset deassert is synchronous to `clk`.
- Reset asserted mid-stall discards the held instruction. No output glitches to `ex_valid=1` during reset.
- Capture latency is 1 cycle: decode accepted at edge N gives `ex_valid` and operands visible after edge N.
- `id_ready` is combinational from the current-cycle inputs and stage state. There is no combinational path from `ex_ready` to any registered output.
- Load-use case, with the load held in EX and a dependent instruction in ID:
  - Cycle 1: `ex_result_ok=0`, so stall.
  - Cycle 2: the load is in MEM. If `mem_data_ok=0`, stall.
  - The next cycle forwards from WB. Total is 1–2 bubbles, depending on `mem_data_ok`.
- `flush` and `ex_ready=0` in the same cycle: flush wins, and `ex_valid` drops next cycle.
- Same-cycle WB write and register-file read of the same index: the bypass supplies `wb_data`, and the register file is not relied on for write-through.

## Test plan
- Independent ALU ops back-to-back: `id_rs1=3`, RF returns 0x11, no producer matches. Result: `ex_rs1_data=0x11` one cycle later, `id_ready` stays 1, `stall_cnt=0`.
- EX-to-ID forwarding: producer `ex_rd=5`, `ex_result=0xA5`, `ex_result_ok=1`; consumer `rs2=5`. Result: `ex_rs2_data=0xA5`, no stall. Repeat with `rd=0`: the consumer gets 0.
- Priority: EX, MEM and WB all target x7 with 0x1, 0x2, 0x3, and EX is ready. Result: 0x1. With EX unready: stall, not 0x2.
- Load-use: the load writes x9; dependent `rs1=9`; `mem_data_ok=0` for one cycle, then WB `wb_data=0xDEAD`. Result: 2 bubbles, `stall_cnt=2`, `ex_rs1_data=0xDEAD`.
- Back-pressure: `ex_ready=0` for 3 cycles with `ex_valid=1`. Result: outputs frozen, `id_ready=0`. `flush` on cycle 2 gives `ex_valid=0` next cycle.
- Async reset mid-hold: drop `rst` between edges. Result: `ex_valid=0` and `stall_cnt=0` immediately; after release, the first accepted instruction captures correctly.
